edge_frame_stats: RTL and testbench

//  Downstream stage of the Sobel convolution kernel, in the VGA_CLK domain.

---
 rtl/edge_frame_stats.sv | 151 +++++++++++++++
 tb/tb_edge_frame_stats.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_stats.sv
// Output stage of the Sobel edge kernel: colour mode mux with 2-cycle fixed latency,
// plus a per-frame count of above-threshold visible pixels.
//
// state      | meaning
// WAIT_FRAME | after reset; partial first frame discarded, accumulator held at 0
// COUNTING   | accumulating hits; each vsync fall publishes the closed frame's count

module edge_frame_stats #(
  parameter int PIXEL_DEPTH = 8,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   RESET_N,
  input  logic                   vs_ni,
  input  logic                   hs_ni,
  input  logic                   blank_ni,
  input  logic [PIXEL_DEPTH-1:0] inputEdge,
  input  logic [PIXEL_DEPTH-1:0] inputLUM,
  input  logic [PIXEL_DEPTH-1:0] threshold,
  input  logic [1:0]             mode,
  output logic                   vs_no,
  output logic                   hs_no,
  output logic                   blank_no,
  output logic [PIXEL_DEPTH-1:0] oR,
  output logic [PIXEL_DEPTH-1:0] oG,
  output logic [PIXEL_DEPTH-1:0] oB,
  output logic [COUNT_WIDTH-1:0] edge_count,
  output logic                   count_valid
);

  typedef enum logic {WAIT_FRAME, COUNTING} state_t;

  localparam logic [PIXEL_DEPTH-1:0] PIX_MAX = {PIXEL_DEPTH{1'b1}};
  localparam logic [PIXEL_DEPTH-1:0] PIX_MIN = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  logic                   vs1_q, hs1_q, blank1_q, hit1_q;
  logic [PIXEL_DEPTH-1:0] edge1_q, lum1_q;
  logic [1:0]             mode1_q;

  logic                   vs2_q, hs2_q, blank2_q;
  logic [PIXEL_DEPTH-1:0] r2_q, g2_q, b2_q;
  logic [PIXEL_DEPTH-1:0] r2_d, g2_d, b2_d;

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] acc_q, edge_count_q, acc_sum_d;
  logic                   count_valid_q;
  logic                   vs_fall;

  // Stage 1: register inputs; threshold and mode take effect from the sampled pixel.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      vs1_q    <= 1'b1;
      hs1_q    <= 1'b1;
      blank1_q <= 1'b0;
      hit1_q   <= 1'b0;
      edge1_q  <= '0;
      lum1_q   <= '0;
      mode1_q  <= '0;
    end else begin
      vs1_q    <= vs_ni;
      hs1_q    <= hs_ni;
      blank1_q <= blank_ni;
      hit1_q   <= blank_ni & (inputEdge >= threshold);
      edge1_q  <= inputEdge;
      lum1_q   <= inputLUM;
      mode1_q  <= mode;
    end
  end

  always_comb begin
    r2_d = PIX_MIN;
    g2_d = PIX_MIN;
    b2_d = PIX_MIN;
    if (blank1_q) begin
      unique case (mode1_q)
        2'd0: begin r2_d = edge1_q; g2_d = edge1_q; b2_d = edge1_q; end
        2'd1: begin
          r2_d = hit1_q ? PIX_MAX : PIX_MIN;
          g2_d = r2_d;
          b2_d = r2_d;
        end
        2'd2: begin
          r2_d = hit1_q ? PIX_MAX : lum1_q;
          g2_d = hit1_q ? PIX_MIN : lum1_q;
          b2_d = hit1_q ? PIX_MIN : lum1_q;
        end
        default: begin r2_d = lum1_q; g2_d = lum1_q; b2_d = lum1_q; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      vs2_q    <= 1'b1;
      hs2_q    <= 1'b1;
      blank2_q <= 1'b0;
      r2_q     <= '0;
      g2_q     <= '0;
      b2_q     <= '0;
    end else begin
      vs2_q    <= vs1_q;
      hs2_q    <= hs1_q;
      blank2_q <= blank1_q;
      r2_q     <= r2_d;
      g2_q     <= g2_d;
      b2_q     <= b2_d;
    end
  end

  // The hit sitting in stage 1 on the vsync-fall cycle still belongs to the closing frame.
  assign vs_fall   = vs1_q & ~vs_ni;
  assign acc_sum_d = (acc_q == CNT_MAX) ? CNT_MAX
                                        : acc_q + {{(COUNT_WIDTH-1){1'b0}}, hit1_q};

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state_q       <= WAIT_FRAME;
      acc_q         <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
    end else begin
      count_valid_q <= 1'b0;
      unique case (state_q)
        WAIT_FRAME: begin
          acc_q <= '0;
          if (vs_fall) state_q <= COUNTING;
        end
        default: begin
          if (vs_fall) begin
            edge_count_q  <= acc_sum_d;
            count_valid_q <= 1'b1;
            acc_q         <= '0;
          end else begin
            acc_q <= acc_sum_d;
          end
        end
      endcase
    end
  end

  assign vs_no       = vs2_q;
  assign hs_no       = hs2_q;
  assign blank_no    = blank2_q;
  assign oR          = r2_q;
  assign oG          = g2_q;
  assign oB          = b2_q;
  assign edge_count  = edge_count_q;
  assign count_valid = count_valid_q;

endmodule

// File: tb/tb_edge_frame_stats.sv
// Scoreboard bench for edge_frame_stats: a per-cycle reference model pushes expected
// outputs; a monitor pops and compares them against a 20-bit and a 4-bit counter instance.

module tb_edge_frame_stats;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic       vs_ni = 1'b1, hs_ni = 1'b1, blank_ni = 1'b0;
  logic [7:0] inputEdge = '0, inputLUM = '0, threshold = '0;
  logic [1:0] mode = '0;

  logic        vs_no, hs_no, blank_no, count_valid;
  logic [7:0]  oR, oG, oB;
  logic [19:0] edge_count;
  logic        vs4, hs4, bl4, cv4;
  logic [7:0]  r4, g4, b4;
  logic [3:0]  ec4;

  always #5 clk = ~clk;

  edge_frame_stats #(.PIXEL_DEPTH(8), .COUNT_WIDTH(20)) dut (
    .clk(clk), .RESET_N(RESET_N), .vs_ni(vs_ni), .hs_ni(hs_ni), .blank_ni(blank_ni),
    .inputEdge(inputEdge), .inputLUM(inputLUM), .threshold(threshold), .mode(mode),
    .vs_no(vs_no), .hs_no(hs_no), .blank_no(blank_no), .oR(oR), .oG(oG), .oB(oB),
    .edge_count(edge_count), .count_valid(count_valid));

  edge_frame_stats #(.PIXEL_DEPTH(8), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .RESET_N(RESET_N), .vs_ni(vs_ni), .hs_ni(hs_ni), .blank_ni(blank_ni),
    .inputEdge(inputEdge), .inputLUM(inputLUM), .threshold(threshold), .mode(mode),
    .vs_no(vs4), .hs_no(hs4), .blank_no(bl4), .oR(r4), .oG(g4), .oB(b4),
    .edge_count(ec4), .count_valid(cv4));

  typedef struct {
    int          cyc;
    logic [2:0]  syncs;   // {vs, hs, blank}
    logic [23:0] rgb;
    logic        cv;
    logic [19:0] ec;
    logic [3:0]  ec4;
  } exp_t;

  exp_t q[$];
  int vectors = 0, miscompares = 0, cyc = 0;

  // reference model state
  bit         m_wait = 1'b1, m_pvalid = 1'b0, m_pvs = 1'b1, m_phit = 1'b0;
  int         m_acc = 0, m_acc4 = 0, m_ec = 0, m_ec4 = 0;
  logic [2:0]  m_psync;
  logic [23:0] m_prgb;

  function automatic logic [23:0] colour(input bit bl, input logic [7:0] e, l, th,
                                         input logic [1:0] md);
    bit hit;
    hit = bl && (e >= th);
    if (!bl) return 24'h000000;
    case (md)
      2'd0:    return {e, e, e};
      2'd1:    return hit ? 24'hFFFFFF : 24'h000000;
      2'd2:    return hit ? 24'hFF0000 : {l, l, l};
      default: return {l, l, l};
    endcase
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic step(input bit rst, input bit vs, input bit hs, input bit bl,
                      input logic [7:0] e, input logic [7:0] l, input logic [7:0] th,
                      input logic [1:0] md);
    exp_t x;
    bit   fall;
    @(negedge clk);
    RESET_N = rst; vs_ni = vs; hs_ni = hs; blank_ni = bl;
    inputEdge = e; inputLUM = l; threshold = th; mode = md;
    x.cyc = cyc; cyc++;
    x.cv  = 1'b0;
    if (!rst) begin
      x.syncs = 3'b110; x.rgb = '0;
      m_wait = 1'b1; m_acc = 0; m_acc4 = 0; m_ec = 0; m_ec4 = 0;
      m_pvs = 1'b1; m_phit = 1'b0; m_pvalid = 1'b0;
    end else begin
      if (m_pvalid) begin x.syncs = m_psync; x.rgb = m_prgb; end
      else begin x.syncs = 3'b110; x.rgb = '0; end
      fall = m_pvs && !vs;
      if (m_wait) begin
        if (fall) m_wait = 1'b0;
      end else if (fall) begin
        m_ec  = sat(m_acc + int'(m_phit), 20'hFFFFF);
        m_ec4 = sat(m_acc4 + int'(m_phit), 15);
        m_acc = 0; m_acc4 = 0; x.cv = 1'b1;
      end else begin
        m_acc  = sat(m_acc + int'(m_phit), 20'hFFFFF);
        m_acc4 = sat(m_acc4 + int'(m_phit), 15);
      end
      m_pvs = vs; m_phit = bl && (e >= th); m_pvalid = 1'b1;
      m_psync = {vs, hs, bl}; m_prgb = colour(bl, e, l, th, md);
    end
    x.ec = 20'(m_ec); x.ec4 = 4'(m_ec4);
    q.push_back(x);
  endtask

  // Monitor: one expected entry per clock, compared just after the active edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        vectors++;
        if ({vs_no, hs_no, blank_no, oR, oG, oB} !== {x.syncs, x.rgb}) begin
          miscompares++;
          $display("FAIL pix cyc %0d: got sync=%b rgb=%h, expected sync=%b rgb=%h",
                   x.cyc, {vs_no, hs_no, blank_no}, {oR, oG, oB}, x.syncs, x.rgb);
        end
        if ({vs4, hs4, bl4, r4, g4, b4} !== {x.syncs, x.rgb}) begin
          miscompares++;
          $display("FAIL pix4 cyc %0d: got sync=%b rgb=%h, expected sync=%b rgb=%h",
                   x.cyc, {vs4, hs4, bl4}, {r4, g4, b4}, x.syncs, x.rgb);
        end
        if (count_valid !== x.cv || edge_count !== x.ec) begin
          miscompares++;
          $display("FAIL count cyc %0d: got valid=%b count=%0d, expected valid=%b count=%0d",
                   x.cyc, count_valid, edge_count, x.cv, x.ec);
        end
        if (cv4 !== x.cv || ec4 !== x.ec4) begin
          miscompares++;
          $display("FAIL count4 cyc %0d: got valid=%b count=%0d, expected valid=%b count=%0d",
                   x.cyc, cv4, ec4, x.cv, x.ec4);
        end
      end
    end
  end

  // pat 0: every 4th pixel 0xFF; 1: random pixels/modes/blank; 2: all 0xFF
  task automatic frame(input int w, input int h, input int pat, input logic [7:0] th,
                       input logic [1:0] md);
    logic [7:0] e;
    logic [1:0] m;
    bit         bl;
    repeat (2) step(1, 0, 1, 0, 8'h00, 8'h00, th, md);
    for (int y = 0; y < h; y++) begin
      repeat (3) step(1, 1, 0, 0, 8'hFF, 8'h11, th, md);
      for (int x = 0; x < w; x++) begin
        m = md; bl = 1'b1;
        case (pat)
          0:       e = (x % 4 == 0) ? 8'hFF : 8'h00;
          1: begin
            e  = 8'($urandom_range(0, 255));
            m  = 2'($urandom_range(0, 3));
            bl = ($urandom_range(0, 9) != 0);
          end
          default: e = 8'hFF;
        endcase
        step(1, 1, 1, bl, e, 8'($urandom_range(0, 255)), th, m);
      end
    end
    repeat (2) step(1, 1, 1, 0, 8'hFF, 8'h22, th, md);
  endtask

  initial begin
    repeat (3) step(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    step(1, 1, 1, 1, 8'h5A, 8'h33, 8'h00, 2'd0);
    step(1, 1, 0, 1, 8'h12, 8'h33, 8'h00, 2'd0);
    step(1, 1, 1, 1, 8'h7F, 8'h40, 8'h80, 2'd1);
    step(1, 1, 1, 1, 8'h80, 8'h40, 8'h80, 2'd1);
    step(1, 1, 1, 1, 8'h7F, 8'h40, 8'h80, 2'd2);
    step(1, 1, 1, 1, 8'h80, 8'h40, 8'h80, 2'd2);
    step(1, 1, 1, 0, 8'hFF, 8'h40, 8'h10, 2'd3);
    step(1, 1, 1, 1, 8'h00, 8'h40, 8'h10, 2'd3);
    repeat (100) step(1, 1, 1, 1, 8'hFF, 8'h55, 8'h10, 2'd0);

    frame(40, 30, 0, 8'h10, 2'd1);
    for (int i = 0; i < 3; i++)
      frame(24, 6, 1, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));

    // vsync held low: only one fall
    repeat (20) step(1, 0, 1, 0, 8'hFF, 8'h00, 8'h10, 2'd0);
    repeat (5) step(1, 1, 1, 1, 8'hFF, 8'h00, 8'h10, 2'd0);

    // reset mid-frame
    repeat (30) step(1, 1, 1, 1, 8'hFF, 8'h66, 8'h10, 2'd2);
    repeat (2) step(0, 1, 1, 1, 8'hFF, 8'h66, 8'h10, 2'd2);
    repeat (10) step(1, 1, 1, 1, 8'hFF, 8'h66, 8'h10, 2'd2);
    frame(20, 1, 2, 8'h10, 2'd0);
    frame(20, 1, 2, 8'h10, 2'd3);
    repeat (3) step(1, 0, 1, 0, 8'h00, 8'h00, 8'h10, 2'd0);
    repeat (4) step(1, 1, 1, 0, 8'h00, 8'h00, 8'h10, 2'd0);

    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
